minutnik_odliczanie: RTL and testbench
======================================

Name: minutnik_odliczanie

Overview:
- Countdown timer (kitchen-timer style) that produces the 13-bit seconds value consumed by the display-handling stage (range 0..5999, shown as MM:SS).
- Accepts raw push-buttons, synchronises them and lets the user set minutes/seconds, start/pause/clear the countdown.
- Raises an alarm flag for a fixed time when the count reaches zero.

Parameters:
CLK_HZ, 100000000, i_CLK frequency; the 1 Hz tick period in cycles.
CZAS_MAX, 5999, maximum settable time in seconds (99:59).
ALARM_S, 10, alarm duration in seconds.

Ports:
i_CLK  input  1  system clock
i_RST_N  input  1  asynchronous active-low reset
i_Start  input  1  raw button: start/pause/acknowledge, active-high, asynchronous to i_CLK
i_Min  input  1  raw button: +1 minute, active-high, asynchronous
i_Sek  input  1  raw button: +1 second, active-high, asynchronous
i_Kasuj  input  1  raw button: clear, active-high, asynchronous
o_Czas  output  13  remaining time in seconds, registered, 0..CZAS_MAX
o_Alarm  output  1  high while in ALARM state
o_Stan  output  2  state code: 00 SET, 01 RUN, 10 PAUSE, 11 ALARM

Behaviour:
- Reset (i_RST_N low, asynchronous): state SET, o_Czas=0, o_Alarm=0, prescaler=0, alarm counter=0, all synchroniser flops=0.
- Button conditioning: each input uses a 2-FF synchroniser followed by a delay flop; pulse = sync & ~delayed (one cycle per rising edge).
- Input-to-output latency: an input first sampled high at edge N produces a pulse after edge N+1; o_Czas/o_Stan update at edge N+2.
- Pulse priority in one cycle: Kasuj > Start > Min > Sek. Only the highest pending pulse acts; the others are dropped.
- Prescaler: counts 0..CLK_HZ-1 in RUN and ALARM only. tick = (count==CLK_HZ-1), then count wraps to 0.
  - The count is held in PAUSE.
  - The count is cleared on SET->RUN and on entry to ALARM.
- SET:
  - Min: if o_Czas+60 > CZAS_MAX, then o_Czas -= 5940 (minutes wrap to 0, seconds kept); else o_Czas += 60.
  - Sek: if o_Czas%60 == 59, then o_Czas -= 59 (no carry into minutes); else o_Czas += 1.
  - Kasuj: o_Czas=0.
  - Start: if o_Czas != 0, go to RUN; if o_Czas == 0, ignored.
- RUN:
  - On tick: o_Czas -= 1. If the new value is 0, go to ALARM and load the alarm counter with ALARM_S.
  - Start: go to PAUSE. If a tick occurs in the same cycle, the decrement is still applied. If that decrement reaches 0, ALARM wins over PAUSE.
  - Kasuj: go to SET, o_Czas=0, prescaler=0.
  - Min/Sek: ignored.
- PAUSE:
  - Start: go to RUN; the prescaler resumes from its held value.
  - Kasuj: go to SET, o_Czas=0, prescaler=0.
  - Min/Sek: ignored.
- ALARM:
  - o_Alarm=1 and o_Czas=0.
  - On tick: alarm counter -= 1. When it reaches 0, go to SET.
  - Start or Kasuj: go to SET immediately.
  - o_Alarm falls in the same cycle the state leaves ALARM.
- o_Czas never exceeds CZAS_MAX and never underflows. All arithmetic is 13-bit unsigned.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: MINUTNIK_AUTOREPEAT_EN.
- Defined: in SET, if the synchronised i_Min or i_Sek stays high continuously for CLK_HZ cycles, the block generates an extra increment pulse for that button immediately.
  - Further pulses then follow every CLK_HZ/4 cycles while the button is held.
  - Releasing the button resets the hold counter.
  - Auto-repeat pulses follow the normal priority and wrap rules.
- Undefined: exactly one increment per press; the hold counter logic is absent.

Test Plan:
- Bench parameters: CLK_HZ=10, ALARM_S=3.
- Reset with i_Min held high → o_Czas=0, o_Stan=00. After release, one i_Min press → o_Czas=60 exactly 2 edges after the first high sample.
- In SET at o_Czas=5999 (99:59): press Min → 59; press Sek → 0; from 0 press Start → stays SET, o_Czas=0.
- Set o_Czas=3, press Start → o_Stan=01 and decrements every 10 cycles (3,2,1,0).
  - On reaching 0: o_Stan=11, o_Alarm=1 for 30 cycles, then o_Stan=00, o_Alarm=0.
- RUN at o_Czas=65: press Start after 4 cycles into a second → PAUSE, o_Czas frozen for 50 cycles. Press Start again → next decrement after 6 more cycles (resume).
- Kasuj and Start pressed in the same cycle during RUN → SET, o_Czas=0. Assert i_RST_N low mid-ALARM → o_Alarm=0 and o_Stan=00 immediately, asynchronously.
- With MINUTNIK_AUTOREPEAT_EN defined: hold i_Sek for 20 cycles from o_Czas=0 → o_Czas=1 after press, 2 at hold cycle 10, then 3, 4, … every 2 cycles (CLK_HZ/4 = 2, integer division) until release.

Source files
------------

// File: rtl/minutnik_odliczanie_if.sv
// rtl/minutnik_odliczanie_if.sv - button inputs and display outputs of the countdown timer
interface minutnik_odliczanie_if;
  logic        i_Start;
  logic        i_Min;
  logic        i_Sek;
  logic        i_Kasuj;
  logic [12:0] o_Czas;
  logic        o_Alarm;
  logic [1:0]  o_Stan;

  modport master (
    output i_Start, i_Min, i_Sek, i_Kasuj,
    input  o_Czas, o_Alarm, o_Stan
  );

  modport slave (
    input  i_Start, i_Min, i_Sek, i_Kasuj,
    output o_Czas, o_Alarm, o_Stan
  );
endinterface

// File: rtl/minutnik_odliczanie.sv
// rtl/minutnik_odliczanie.sv - kitchen countdown timer producing seconds for an MM:SS display
// MINUTNIK_AUTOREPEAT_EN: held Min/Sek in SET auto-repeat after CLK_HZ cycles, then every CLK_HZ/4.
module minutnik_odliczanie #(
  parameter int CLK_HZ   = 100000000,
  parameter int CZAS_MAX = 5999,
  parameter int ALARM_S  = 10
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  minutnik_odliczanie_if.slave bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int AW = $clog2(ALARM_S + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [12:0]   MAX13      = 13'(CZAS_MAX);

  typedef enum logic [1:0] {SET = 2'b00, RUN = 2'b01, PAUSE = 2'b10, ALARM = 2'b11} stan_t;

  stan_t         stan_q, stan_d;
  logic [12:0]   czas_q, czas_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] alarm_q, alarm_d;
  logic [3:0]    sync1, sync2, dly;
  logic [3:0]    pulse, cmd;
  logic          tick;
  logic          do_kasuj, do_start, do_min, do_sek;

  // bit order everywhere: {Kasuj, Start, Min, Sek}
  assign pulse = sync2 & ~dly;

`ifdef MINUTNIK_AUTOREPEAT_EN
  localparam int RPT = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int HW  = $clog2(CLK_HZ + 1);
  localparam logic [HW-1:0] HOLD_FIRST  = HW'(CLK_HZ);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(CLK_HZ - RPT);

  logic [HW-1:0] hold_q [2];
  logic [1:0]    rpt;

  always_comb begin
    rpt = '0;
    for (int i = 0; i < 2; i++)
      rpt[i] = (stan_q == SET) && sync2[i] && (hold_q[i] == HOLD_FIRST);
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      hold_q[0] <= '0;
      hold_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (stan_q == SET && sync2[i])
          hold_q[i] <= rpt[i] ? HOLD_RELOAD : hold_q[i] + 1'b1;
        else
          hold_q[i] <= '0;
      end
    end
  end

  assign cmd = {pulse[3:2], pulse[1:0] | rpt};
`else
  assign cmd = pulse;
`endif

  assign do_kasuj = cmd[3];
  assign do_start = cmd[2] & ~cmd[3];
  assign do_min   = cmd[1] & ~|cmd[3:2];
  assign do_sek   = cmd[0] & ~|cmd[3:1];
  assign tick     = (stan_q == RUN || stan_q == ALARM) && (presc_q == PRESC_LAST);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      sync1   <= '0;
      sync2   <= '0;
      dly     <= '0;
      stan_q  <= SET;
      czas_q  <= '0;
      presc_q <= '0;
      alarm_q <= '0;
    end else begin
      sync1   <= {bus.i_Kasuj, bus.i_Start, bus.i_Min, bus.i_Sek};
      sync2   <= sync1;
      dly     <= sync2;
      stan_q  <= stan_d;
      czas_q  <= czas_d;
      presc_q <= presc_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    stan_d  = stan_q;
    czas_d  = czas_q;
    presc_d = presc_q;
    alarm_d = alarm_q;
    if (stan_q == RUN || stan_q == ALARM)
      presc_d = tick ? '0 : presc_q + 1'b1;
    case (stan_q)
      SET: begin
        if (do_kasuj) begin
          czas_d = '0;
        end else if (do_start) begin
          if (czas_q != 13'd0) begin
            stan_d  = RUN;
            presc_d = '0;
          end
        end else if (do_min) begin
          czas_d = (czas_q + 13'd60 > MAX13) ? czas_q - 13'd5940 : czas_q + 13'd60;
        end else if (do_sek) begin
          czas_d = (czas_q % 13'd60 == 13'd59) ? czas_q - 13'd59 : czas_q + 13'd1;
        end
      end
      RUN: begin
        if (tick && czas_q != 13'd0)
          czas_d = czas_q - 13'd1;
        if (do_kasuj) begin
          stan_d  = SET;
          czas_d  = '0;
          presc_d = '0;
        end else if (tick && czas_q == 13'd1) begin
          stan_d  = ALARM;
          alarm_d = AW'(ALARM_S);
          presc_d = '0;
        end else if (do_start) begin
          stan_d = PAUSE;
        end
      end
      PAUSE: begin
        if (do_kasuj) begin
          stan_d  = SET;
          czas_d  = '0;
          presc_d = '0;
        end else if (do_start) begin
          stan_d = RUN;
        end
      end
      ALARM: begin
        czas_d = '0;
        if (do_kasuj || do_start) begin
          stan_d = SET;
        end else if (tick) begin
          alarm_d = alarm_q - 1'b1;
          if (alarm_q == AW'(1))
            stan_d = SET;
        end
      end
      default: stan_d = SET;
    endcase
  end

  always_comb begin
    bus.o_Czas  = czas_q;
    bus.o_Stan  = stan_q;
    bus.o_Alarm = (stan_q == ALARM);
  end

endmodule

// File: tb/tb_minutnik_odliczanie.sv
// tb/tb_minutnik_odliczanie.sv - randomized scoreboard bench for the countdown timer
module tb_minutnik_odliczanie;
  localparam int CLK_HZ   = 10;
  localparam int CZAS_MAX = 5999;
  localparam int ALARM_S  = 3;
`ifdef MINUTNIK_AUTOREPEAT_EN
  localparam int RPT = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int HOLD_FINAL = 6;
`else
  localparam int HOLD_FINAL = 1;
`endif

  logic i_CLK   = 1'b0;
  logic i_RST_N = 1'b0;

  minutnik_odliczanie_if bus ();

  minutnik_odliczanie #(
    .CLK_HZ  (CLK_HZ),
    .CZAS_MAX(CZAS_MAX),
    .ALARM_S (ALARM_S)
  ) dut (
    .i_CLK  (i_CLK),
    .i_RST_N(i_RST_N),
    .bus    (bus)
  );

  always #5 i_CLK = ~i_CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge i_CLK) cyc <= cyc + 1;

  typedef struct {
    int edge_n;
    int czas;
    int stan;
    int alarm;
  } exp_t;
  exp_t sbq[$];

  // Reference model: state 0 SET, 1 RUN, 2 PAUSE, 3 ALARM; m_cnt counts cycles spent counting
  int       m_stan, m_czas, m_cnt;
  bit [3:0] pend [int];
  bit [3:0] lvl  [int];
  bit [3:0] cur_lv;
`ifdef MINUTNIK_AUTOREPEAT_EN
  int       m_hold [2];
`endif

  task automatic check(input string name, input int e, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s edge %0d: got %0d expected %0d", name, e, act, req);
    end
  endtask

  task automatic direct(input string name, input int czas, input int stan, input int alarm);
    check({name, "_czas"}, cyc, int'(bus.o_Czas), czas);
    check({name, "_stan"}, cyc, int'(bus.o_Stan), stan);
    check({name, "_alarm"}, cyc, int'(bus.o_Alarm), alarm);
  endtask

  task automatic model_reset();
    m_stan = 0;
    m_czas = 0;
    m_cnt  = 0;
    cur_lv = '0;
    pend.delete();
    lvl.delete();
    sbq.delete();
`ifdef MINUTNIK_AUTOREPEAT_EN
    m_hold[0] = 0;
    m_hold[1] = 0;
`endif
  endtask

  function automatic bit [3:0] lvl_at(input int k);
    return lvl.exists(k) ? lvl[k] : 4'b0000;
  endfunction

  // Outcome of clock edge e: a button press first sampled at edge k acts at edge k+2
  task automatic model_edge(input int e);
    bit [3:0] ev;
    bit [3:0] held;
    bit       tick;
    int       hi;
    ev   = pend.exists(e) ? pend[e] : 4'b0000;
    held = lvl_at(e - 2);
`ifdef MINUTNIK_AUTOREPEAT_EN
    for (int b = 0; b < 2; b++) begin
      if (m_stan == 0 && held[b]) m_hold[b]++;
      else m_hold[b] = 0;
      if (m_hold[b] - 1 >= CLK_HZ && ((m_hold[b] - 1 - CLK_HZ) % RPT) == 0) ev[b] = 1'b1;
    end
`else
    if (held == 4'hF) ev = ev;
`endif
    hi = ev[3] ? 3 : ev[2] ? 2 : ev[1] ? 1 : ev[0] ? 0 : -1;
    tick = 1'b0;
    if (m_stan == 1 || m_stan == 3) begin
      m_cnt++;
      tick = (m_cnt % CLK_HZ) == 0;
    end
    case (m_stan)
      0: begin
        if (hi == 3) m_czas = 0;
        else if (hi == 2) begin
          if (m_czas != 0) begin m_stan = 1; m_cnt = 0; end
        end else if (hi == 1) m_czas = (m_czas + 60 > CZAS_MAX) ? m_czas - 5940 : m_czas + 60;
        else if (hi == 0) m_czas = (m_czas % 60 == 59) ? m_czas - 59 : m_czas + 1;
      end
      1: begin
        if (tick) m_czas--;
        if (hi == 3) begin m_stan = 0; m_czas = 0; m_cnt = 0; end
        else if (tick && m_czas == 0) begin m_stan = 3; m_cnt = 0; end
        else if (hi == 2) m_stan = 2;
      end
      2: begin
        if (hi == 3) begin m_stan = 0; m_czas = 0; m_cnt = 0; end
        else if (hi == 2) m_stan = 1;
      end
      default: begin
        if (hi >= 2) m_stan = 0;
        else if (m_cnt == ALARM_S * CLK_HZ) m_stan = 0;
      end
    endcase
  endtask

  // Called just after a falling edge: levels set here are sampled at the next rising edge
  task automatic drive_now(input bit [3:0] lv);
    int       c;
    bit [3:0] rise;
    exp_t     x;
    c    = cyc;
    rise = lv & ~cur_lv;
    bus.i_Kasuj = lv[3];
    bus.i_Start = lv[2];
    bus.i_Min   = lv[1];
    bus.i_Sek   = lv[0];
    lvl[c + 1] = lv;
    cur_lv = lv;
    if (rise != 0) pend[c + 3] = (pend.exists(c + 3) ? pend[c + 3] : 4'b0000) | rise;
    model_edge(c + 1);
    x.edge_n = c + 1;
    x.czas   = m_czas;
    x.stan   = m_stan;
    x.alarm  = (m_stan == 3) ? 1 : 0;
    sbq.push_back(x);
  endtask

  task automatic step(input bit [3:0] lv);
    @(negedge i_CLK);
    drive_now(lv);
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000);
  endtask

  task automatic press(input bit [3:0] b);
    step(b);
    step(b);
    step(4'b0000);
    step(4'b0000);
  endtask

  initial begin
    forever begin
      @(posedge i_CLK);
      #2;
      while (sbq.size() > 0 && sbq[0].edge_n <= cyc) begin
        exp_t x;
        x = sbq.pop_front();
        check("sb_czas", x.edge_n, int'(bus.o_Czas), x.czas);
        check("sb_stan", x.edge_n, int'(bus.o_Stan), x.stan);
        check("sb_alarm", x.edge_n, int'(bus.o_Alarm), x.alarm);
      end
    end
  end

  initial begin
    model_reset();
    bus.i_Kasuj = 1'b0;
    bus.i_Start = 1'b0;
    bus.i_Sek   = 1'b0;
    bus.i_Min   = 1'b1;
    repeat (3) @(negedge i_CLK);
    direct("reset_min_held", 0, 0, 0);
    bus.i_Min = 1'b0;
    @(negedge i_CLK);
    i_RST_N = 1'b1;
    drive_now(4'b0000);

    // one Min press: first sampled at edge c+1, visible after edge c+3
    step(4'b0010);
    step(4'b0010);
    step(4'b0000);
    direct("min_latency_early", 0, 0, 0);
    step(4'b0000);
    direct("min_latency", 60, 0, 0);

    press(4'b1000);
    idle(2);
    direct("kasuj_set", 0, 0, 0);
    repeat (99) press(4'b0010);
    repeat (59) press(4'b0001);
    idle(2);
    direct("max_time", 5999, 0, 0);
    press(4'b0010);
    idle(2);
    direct("min_wrap", 59, 0, 0);
    press(4'b0001);
    idle(2);
    direct("sek_wrap", 0, 0, 0);
    press(4'b0100);
    idle(2);
    direct("start_at_zero", 0, 0, 0);

    repeat (3) press(4'b0001);
    press(4'b0100);
    idle(70);
    direct("after_alarm", 0, 0, 0);

    press(4'b0010);
    repeat (5) press(4'b0001);
    press(4'b0100);
    idle(12);
    press(4'b0100);
    idle(50);
    press(4'b0100);
    idle(30);
    press(4'b1000);
    idle(3);
    direct("pause_clear", 0, 0, 0);

    repeat (2) press(4'b0001);
    press(4'b0100);
    idle(5);
    press(4'b1100);
    idle(3);
    direct("kasuj_start_run", 0, 0, 0);

    repeat (20) step(4'b0001);
    idle(3);
    direct("hold_sek", HOLD_FINAL, 0, 0);
    press(4'b1000);

    repeat (150) begin
      int       r;
      int       len;
      bit [3:0] b;
      r = $urandom_range(0, 9);
      if (r <= 3) b = 4'b0001;
      else if (r <= 5) b = 4'b0010;
      else if (r <= 7) b = 4'b0100;
      else if (r == 8) b = 4'b1000;
      else b = 4'($urandom_range(1, 15));
      len = $urandom_range(1, 3);
      repeat (len) step(b);
      step(4'b0000);
      idle($urandom_range(0, 25));
    end

    press(4'b1000);
    press(4'b1000);
    repeat (2) press(4'b0001);
    press(4'b0100);
    for (int i = 0; i < 100 && bus.o_Stan != 2'b11; i++) step(4'b0000);
    check("reach_alarm", cyc, int'(bus.o_Stan), 3);
    idle(5);
    #2;
    i_RST_N = 1'b0;
    sbq.delete();
    #1;
    direct("async_reset_alarm", 0, 0, 0);
    @(negedge i_CLK);
    @(negedge i_CLK);
    model_reset();
    i_RST_N = 1'b1;
    drive_now(4'b0000);
    press(4'b0010);
    idle(3);
    direct("after_reset_min", 60, 0, 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
